regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file; successor to the fixed 32x32 2-read file. Sits in the
//  processor decode/writeback stage. Adds N read ports, K handshaked external write channels
//  (game module -> CPU mailbox registers) with CPU-conflict buffering, and a contiguous tap window
//  exporting registers to the game module.
// PARAMETERS
//  DATA_W    32  register width
//  ADDR_W    5   address width; depth = 2**ADDR_W
//  NUM_RD    2   combinational read ports
//  NUM_EXT   1   external write channels; channel e owns register EXT_BASE+e
//  EXT_BASE  25  first external-owned register (>=1; EXT_BASE+NUM_EXT <= 2**ADDR_W)
//  TAP_BASE  20  first tapped register
//  NUM_TAP   7   tapped registers (TAP_BASE+NUM_TAP <= 2**ADDR_W)
// PORTS
//  clock             in   1               single clock, rising edge
//  ctrl_reset        in   1               synchronous, active-high reset
//  ctrl_writeEnable  in   1               CPU write strobe
//  ctrl_writeReg     in   ADDR_W          CPU write address
//  data_writeReg     in   DATA_W          CPU write data
//  ctrl_readReg      in   NUM_RD*ADDR_W   read addresses, port p at [p*ADDR_W +: ADDR_W]
//  data_readReg      out  NUM_RD*DATA_W   read data, port p at [p*DATA_W +: DATA_W]
//  ext_valid         in   NUM_EXT         channel e offers ext_data
//  ext_data          in   NUM_EXT*DATA_W  channel e write data
//  ext_ready         out  NUM_EXT         channel e can accept
//  tap_data          out  NUM_TAP*DATA_W  tap t = register TAP_BASE+t (registered value)
// BEHAVIOUR
//  - Reset (sync, ctrl_reset=1 at edge): all registers 0, ext buffers empty, ext_ready=0 while
//    ctrl_reset high, 1 first cycle after. Reset mid-transfer discards buffered ext data.
//  - Register 0 reads 0 always; all writes to it (CPU or otherwise) ignored.
//  - CPU write: commits at edge when ctrl_writeEnable=1; visible on reads the next cycle.
//  - Ext channel e: transfer when ext_valid[e]&ext_ready[e]; ext_ready[e] = ~buf_full[e].
//    * No CPU write to EXT_BASE+e this cycle: ext_data commits at this edge (latency 1).
//    * CPU writes EXT_BASE+e same cycle: CPU data commits; ext_data captured in buffer,
//      buf_full=1, ext_ready drops next cycle.
//    * Buffer full: drains at first edge with no CPU write to that register; buf_full clears,
//      ext_ready=1 next cycle. Net effect: ext write always lands after the colliding CPU write.
//  - Reads combinational from register state; all ports independent, may alias.
//  - Taps are direct register outputs; no extra latency.
//  - Parameter violations (ranges above, ext/tap overlap with reg 0) -> elaboration error.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a read whose address equals a register committing at this edge returns
//  the committing value (CPU data, or ext/buffer data when that commits) same cycle; reg 0 still 0.
//  Undefined: reads return pre-edge contents; new value visible next cycle. Taps never bypass.
// STRUCTURE
//  regfile_pkg: DATA_W/ADDR_W defaults, typedefs data_t, addr_t, localparam DEPTH.
//  Sub-module regfile_ext_chan (one per channel): one-entry buffer, conflict detect, ready,
//  commit strobe + commit data to the owning register. Top: storage array, write decode, read muxes.
// TESTING
//  1 Reset: write r5=0xDEADBEEF, assert ctrl_reset 1 cycle -> all reads/taps 0, ext_ready=0 then 1.
//  2 r0: CPU write r0=0xFFFFFFFF -> read r0 = 0; read r3 after r3=0x12 write -> 0x12 next cycle.
//  3 Ext no conflict: ext_valid, ext_data=0xA5A5 -> r25=0xA5A5 next cycle, ext_ready stays 1.
//  4 Conflict: same cycle CPU r25=0x1111, ext 0x2222 -> r25=0x1111, ext_ready=0; next cycle
//    r25=0x2222, ext_ready=1; with CPU writing r25 two cycles in a row buffer holds until free.
//  5 Bypass: CPU write r7=0x77 while reading r7 -> 0x77 same cycle with REGFILE_BYPASS_EN, old
//    value without; tap_data for r20..r26 tracks writes with 1-cycle latency in both builds.
//  6 Params NUM_RD=3, NUM_EXT=2, DATA_W=16: simultaneous ext writes to r25,r26 -> both commit.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: CPU write/read ports, external write channels and tap window.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int NUM_EXT = 1,
  parameter int NUM_TAP = 7
) ();

  logic                        ctrl_writeEnable;
  logic [ADDR_W-1:0]           ctrl_writeReg;
  logic [DATA_W-1:0]           data_writeReg;
  logic [NUM_RD*ADDR_W-1:0]    ctrl_readReg;
  logic [NUM_RD*DATA_W-1:0]    data_readReg;
  logic [NUM_EXT-1:0]          ext_valid;
  logic [NUM_EXT*DATA_W-1:0]   ext_data;
  logic [NUM_EXT-1:0]          ext_ready;
  logic [NUM_TAP*DATA_W-1:0]   tap_data;

  // Master is the CPU/game side, slave is the register file itself.
  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
    output ext_valid, ext_data,
    input  data_readReg, ext_ready, tap_data
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
    input  ext_valid, ext_data,
    output data_readReg, ext_ready, tap_data
  );

endinterface

// File: rtl/regfile_ext_chan.sv
// One external write channel: a single-entry buffer that defers an ext write
// behind a colliding CPU write to the same register.
module regfile_ext_chan
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int REG_IDX = 25
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              ext_valid,
  input  logic [DATA_W-1:0] ext_data,
  output logic              ext_ready,
  output logic              commit_en,
  output logic [DATA_W-1:0] commit_data
);

  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              conflict;

  assign conflict  = cpu_we && (cpu_addr == ADDR_W'(REG_IDX));
  assign ext_ready = ~buf_full_q & ~ctrl_reset;

  // A held entry has priority; new ext data is only taken when the buffer is empty.
  always_comb begin
    buf_full_d  = buf_full_q;
    buf_data_d  = buf_data_q;
    commit_en   = 1'b0;
    commit_data = buf_data_q;
    if (buf_full_q) begin
      if (!conflict) begin
        commit_en  = 1'b1;
        buf_full_d = 1'b0;
      end
    end else if (ext_valid && ext_ready) begin
      if (conflict) begin
        buf_full_d = 1'b1;
        buf_data_d = ext_data;
      end else begin
        commit_en   = 1'b1;
        commit_data = ext_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with handshaked external write channels and a tap window.
// Define REGFILE_BYPASS_EN to forward committing write data to same-cycle reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_EXT  = 1,
  parameter int EXT_BASE = 25,
  parameter int TAP_BASE = 20,
  parameter int NUM_TAP  = 7
) (
  input  logic         clock,
  input  logic         ctrl_reset,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH_L = 2 ** ADDR_W;

  if (NUM_RD < 1 || NUM_EXT < 1 || NUM_TAP < 1) begin : g_bad_count
    $error("regfile_mp: NUM_RD, NUM_EXT and NUM_TAP must be at least 1");
  end
  if (EXT_BASE < 1 || EXT_BASE + NUM_EXT > DEPTH_L) begin : g_bad_ext
    $error("regfile_mp: external register range out of bounds or overlaps r0");
  end
  if (TAP_BASE < 1 || TAP_BASE + NUM_TAP > DEPTH_L) begin : g_bad_tap
    $error("regfile_mp: tap window out of bounds or overlaps r0");
  end

  logic [DATA_W-1:0] regs_q [DEPTH_L];
  logic [DATA_W-1:0] regs_d [DEPTH_L];

  logic [NUM_EXT-1:0] ext_commit;
  logic [NUM_EXT-1:0] ext_ready;
  logic [DATA_W-1:0]  ext_commit_data [NUM_EXT];

  for (genvar e = 0; e < NUM_EXT; e++) begin : g_ext
    regfile_ext_chan #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .REG_IDX (EXT_BASE + e)
    ) u_chan (
      .clock       (clock),
      .ctrl_reset  (ctrl_reset),
      .cpu_we      (bus.ctrl_writeEnable),
      .cpu_addr    (bus.ctrl_writeReg),
      .ext_valid   (bus.ext_valid[e]),
      .ext_data    (bus.ext_data[e*DATA_W +: DATA_W]),
      .ext_ready   (ext_ready[e]),
      .commit_en   (ext_commit[e]),
      .commit_data (ext_commit_data[e])
    );
  end

  assign bus.ext_ready = ext_ready;

  // Channels never commit while the CPU writes their register, so the two sources never collide.
  always_comb begin
    regs_d = regs_q;
    if (bus.ctrl_writeEnable) begin
      regs_d[bus.ctrl_writeReg] = bus.data_writeReg;
    end
    for (int e = 0; e < NUM_EXT; e++) begin
      if (ext_commit[e]) begin
        regs_d[ADDR_W'(EXT_BASE + e)] = ext_commit_data[e];
      end
    end
    regs_d[ADDR_W'(0)] = '0;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH_L; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [ADDR_W-1:0]        rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;

  // The bypass build reads the next-state array, which already holds every committing value.
  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr = bus.ctrl_readReg[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      rd_data[p*DATA_W +: DATA_W] = regs_d[rd_addr];
`else
      rd_data[p*DATA_W +: DATA_W] = regs_q[rd_addr];
`endif
      if (rd_addr == '0) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
      end
    end
  end

  assign bus.data_readReg = rd_data;

  for (genvar t = 0; t < NUM_TAP; t++) begin : g_tap
    assign bus.tap_data[t*DATA_W +: DATA_W] = regs_q[ADDR_W'(TAP_BASE + t)];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default-parameter instance and a 16-bit, 3-read, 2-channel one.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_RD    = 0;
  localparam int K_TAP   = 1;
  localparam int K_RDY   = 2;
  localparam int K_RD2   = 3;
  localparam int K_RDY2  = 4;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] val;
    int          due;
    string       name;
  } exp_t;

  logic clock;
  logic ctrl_reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q [$];

  regfile_mp_if bus ();
  regfile_mp_if #(.DATA_W(16), .NUM_RD(3), .NUM_EXT(2)) bus2 ();

  regfile_mp dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  regfile_mp #(.DATA_W(16), .NUM_RD(3), .NUM_EXT(2)) dut2 (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic ev, input logic [31:0] ed);
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg    = wa;
    bus.data_writeReg    = wd;
    bus.ctrl_readReg     = {ra1, ra0};
    bus.ext_valid        = ev;
    bus.ext_data         = ed;
  endtask

  task automatic expect_out(input int kind, input int idx, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    e.due  = cyc;
    e.name = name;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] sample(input int kind, input int idx);
    logic [31:0] v;
    v = '0;
    case (kind)
      K_RD:    v = bus.data_readReg[idx*32 +: 32];
      K_TAP:   v = bus.tap_data[idx*32 +: 32];
      K_RDY:   v = {31'd0, bus.ext_ready[idx]};
      K_RD2:   v = {16'd0, bus2.data_readReg[idx*16 +: 16]};
      K_RDY2:  v = {31'd0, bus2.ext_ready[idx]};
      default: v = 'x;
    endcase
    return v;
  endfunction

  // Monitor: every falling edge, compare all expectations that have come due.
  exp_t        mon_e;
  int          mon_n;
  logic [31:0] mon_got;
  always @(negedge clock) begin
    mon_n = exp_q.size();
    for (int i = 0; i < mon_n; i++) begin
      mon_e = exp_q.pop_front();
      if (mon_e.due <= cyc) begin
        mon_got = sample(mon_e.kind, mon_e.idx);
        checks++;
        if (mon_got !== mon_e.val) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", mon_e.name, mon_got, mon_e.val, cyc);
        end
      end else begin
        exp_q.push_back(mon_e);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    ctrl_reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    bus2.ctrl_writeEnable = 1'b0;
    bus2.ctrl_writeReg    = '0;
    bus2.data_writeReg    = '0;
    bus2.ctrl_readReg     = '0;
    bus2.ext_valid        = '0;
    bus2.ext_data         = '0;
    next_cycle();
    next_cycle();

    $display("[TB] reset and basic writes");
    ctrl_reset = 1'b0;
    applyStimulus(1, 22, 32'h22, 0, 0, 0, 0);
    expect_out(K_RDY, 0, 1, "ready_after_reset");
    expect_out(K_TAP, 5, 0, "tap5_reset");
    next_cycle();
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    expect_out(K_TAP, 2, 32'h22, "tap2_write");
    next_cycle();
    applyStimulus(0, 0, 0, 5, 0, 0, 0);
    ctrl_reset = 1'b1;
    expect_out(K_RD, 0, 32'hDEADBEEF, "r5_before_reset");
    expect_out(K_RDY, 0, 0, "ready_in_reset");
    next_cycle();
    ctrl_reset = 1'b0;
    expect_out(K_RD, 0, 0, "r5_cleared");
    expect_out(K_TAP, 2, 0, "tap2_cleared");
    expect_out(K_RDY, 0, 1, "ready_post_reset");

    $display("[TB] register zero and CPU writes");
    next_cycle();
    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    expect_out(K_RD, 1, 0, "r0_during_write");
    next_cycle();
    applyStimulus(1, 3, 32'h12, 0, 0, 0, 0);
    expect_out(K_RD, 0, 0, "r0_after_write");
    next_cycle();
    applyStimulus(0, 0, 0, 3, 3, 0, 0);
    expect_out(K_RD, 0, 32'h12, "r3_port0");
    expect_out(K_RD, 1, 32'h12, "r3_port1_alias");

    $display("[TB] external writes");
    next_cycle();
    applyStimulus(0, 0, 0, 25, 0, 1, 32'hA5A5);
    expect_out(K_RD, 0, BYP ? 32'hA5A5 : 32'h0, "r25_ext_bypass");
    expect_out(K_RDY, 0, 1, "ready_ext");
    next_cycle();
    applyStimulus(0, 0, 0, 25, 0, 0, 0);
    expect_out(K_TAP, 5, 32'hA5A5, "tap5_ext");
    expect_out(K_RD, 0, 32'hA5A5, "r25_ext");
    expect_out(K_RDY, 0, 1, "ready_stays");

    next_cycle();
    applyStimulus(1, 25, 32'h1111, 0, 0, 1, 32'h2222);
    expect_out(K_RDY, 0, 1, "ready_conflict_cycle");
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expect_out(K_TAP, 5, 32'h1111, "conflict_cpu_wins");
    expect_out(K_RDY, 0, 0, "ready_buf_full");
    next_cycle();
    expect_out(K_TAP, 5, 32'h2222, "conflict_drained");
    expect_out(K_RDY, 0, 1, "ready_after_drain");

    next_cycle();
    applyStimulus(1, 25, 32'h3333, 0, 0, 1, 32'h4444);
    next_cycle();
    applyStimulus(1, 25, 32'h5555, 0, 0, 0, 0);
    expect_out(K_TAP, 5, 32'h3333, "hold_cpu1");
    expect_out(K_RDY, 0, 0, "hold_ready1");
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expect_out(K_TAP, 5, 32'h5555, "hold_cpu2");
    expect_out(K_RDY, 0, 0, "hold_ready2");
    next_cycle();
    expect_out(K_TAP, 5, 32'h4444, "hold_drained");
    expect_out(K_RDY, 0, 1, "hold_ready3");

    $display("[TB] bypass and taps");
    applyStimulus(1, 7, 32'h70, 0, 0, 0, 0);
    next_cycle();
    applyStimulus(1, 7, 32'h77, 7, 0, 0, 0);
    expect_out(K_RD, 0, BYP ? 32'h77 : 32'h70, "r7_bypass");
    next_cycle();
    applyStimulus(1, 20, 32'hAB, 7, 0, 0, 0);
    expect_out(K_RD, 0, 32'h77, "r7_next");
    expect_out(K_TAP, 0, 0, "tap0_no_bypass");
    next_cycle();
    applyStimulus(1, 26, 32'hCD, 0, 0, 0, 0);
    expect_out(K_TAP, 0, 32'hAB, "tap0_write");
    expect_out(K_TAP, 6, 0, "tap6_no_bypass");
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expect_out(K_TAP, 6, 32'hCD, "tap6_write");

    $display("[TB] two-channel instance");
    bus2.ext_valid = 2'b11;
    bus2.ext_data  = {16'hBB26, 16'hAA25};
    expect_out(K_RDY2, 0, 1, "p2_ready0");
    expect_out(K_RDY2, 1, 1, "p2_ready1");
    next_cycle();
    bus2.ctrl_readReg     = {5'd0, 5'd26, 5'd25};
    bus2.ctrl_writeEnable = 1'b1;
    bus2.ctrl_writeReg    = 5'd26;
    bus2.data_writeReg    = 16'h1234;
    bus2.ext_data         = {16'h2626, 16'h2525};
    expect_out(K_RD2, 0, BYP ? 32'h2525 : 32'hAA25, "p2_r25");
    expect_out(K_RD2, 1, BYP ? 32'h1234 : 32'hBB26, "p2_r26");
    expect_out(K_RD2, 2, 0, "p2_r0");
    next_cycle();
    bus2.ctrl_writeEnable = 1'b0;
    bus2.ext_valid        = 2'b00;
    expect_out(K_RD2, 0, 32'h2525, "p2_r25_second");
    expect_out(K_RD2, 1, BYP ? 32'h2626 : 32'h1234, "p2_r26_cpu");
    expect_out(K_RDY2, 0, 1, "p2_ready0_free");
    expect_out(K_RDY2, 1, 0, "p2_ready1_full");
    next_cycle();
    expect_out(K_RD2, 1, 32'h2626, "p2_r26_drained");
    expect_out(K_RDY2, 1, 1, "p2_ready1_back");
    next_cycle();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clock);
    end
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: never compared, expected %h", mon_e.name, mon_e.val);
    end

    $display("[TB] final state");
    applyStimulus(0, 0, 0, 7, 3, 0, 0);
    #1;
    checks++;
    if (bus.tap_data[0*32 +: 32] !== 32'hAB) begin
      errors++;
      $display("[TB] FAIL final_tap0: got %h expected %h", bus.tap_data[0*32 +: 32], 32'hAB);
    end
    checks++;
    if (bus.tap_data[5*32 +: 32] !== 32'h4444) begin
      errors++;
      $display("[TB] FAIL final_tap5: got %h expected %h", bus.tap_data[5*32 +: 32], 32'h4444);
    end
    checks++;
    if (bus.tap_data[6*32 +: 32] !== 32'hCD) begin
      errors++;
      $display("[TB] FAIL final_tap6: got %h expected %h", bus.tap_data[6*32 +: 32], 32'hCD);
    end
    checks++;
    if (bus.data_readReg[0 +: 32] !== 32'h77) begin
      errors++;
      $display("[TB] FAIL final_r7: got %h expected %h", bus.data_readReg[0 +: 32], 32'h77);
    end
    checks++;
    if (bus.data_readReg[32 +: 32] !== 32'h12) begin
      errors++;
      $display("[TB] FAIL final_r3: got %h expected %h", bus.data_readReg[32 +: 32], 32'h12);
    end
    checks++;
    if (bus2.data_readReg[0 +: 16] !== 16'h2525) begin
      errors++;
      $display("[TB] FAIL final_p2_r25: got %h expected %h", bus2.data_readReg[0 +: 16], 16'h2525);
    end
    checks++;
    if (bus2.data_readReg[16 +: 16] !== 16'h2626) begin
      errors++;
      $display("[TB] FAIL final_p2_r26: got %h expected %h", bus2.data_readReg[16 +: 16], 16'h2626);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
